// File: rtl/daq_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : daq_sync_fifo
// Brief    : Single-clock DAQ FIFO, any depth, optional FWFT, level/flags.
// Revision : 1.0
// ============================================================================
module daq_sync_fifo #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 16,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic                         underflow,
    input  logic                         clr_err
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] c_ptr_last  = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] c_level_max = LVL_W'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_ptr_last) ? '0 : p + 1'b1;
    endfunction

    assign full         = (r_level == c_level_max);
    assign empty        = (r_level == '0);
    assign almost_full  = (32'(r_level) >= 32'(AFULL_THRESH));
    assign almost_empty = (32'(r_level) <= 32'(AEMPTY_THRESH));
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    assign w_wr_acc = wr_en && !full;
    assign w_rd_acc = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            // A new error event wins over a simultaneous clear.
            if (wr_en && full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? '0 : r_mem[r_rd_ptr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_data_out;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_data_out <= '0;
                end else if (w_rd_acc) begin
                    r_data_out <= r_mem[r_rd_ptr];
                end
            end
            assign data_out = r_data_out;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_daq_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_daq_sync_fifo
// Brief    : Self-checking bench: standard (16 deep) and FWFT (5 deep) FIFOs.
// Revision : 1.0
// ============================================================================
module tb_daq_sync_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_wr = 1'b0, a_rd = 1'b0, a_clr = 1'b0;
    logic [31:0] a_din = '0, a_dout;
    logic        a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [4:0]  a_level;

    logic        b_wr = 1'b0, b_rd = 1'b0, b_clr = 1'b0;
    logic [15:0] b_din = '0, b_dout;
    logic        b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [2:0]  b_level;

    daq_sync_fifo #(.DATA_WIDTH(32), .DEPTH(16), .FWFT(0)) u_a (
        .clk(clk), .rst(rst), .wr_en(a_wr), .data_in(a_din), .rd_en(a_rd),
        .data_out(a_dout), .full(a_full), .empty(a_empty), .almost_full(a_af),
        .almost_empty(a_ae), .level(a_level), .overflow(a_ovf),
        .underflow(a_unf), .clr_err(a_clr)
    );

    daq_sync_fifo #(.DATA_WIDTH(16), .DEPTH(5), .FWFT(1)) u_b (
        .clk(clk), .rst(rst), .wr_en(b_wr), .data_in(b_din), .rd_en(b_rd),
        .data_out(b_dout), .full(b_full), .empty(b_empty), .almost_full(b_af),
        .almost_empty(b_ae), .level(b_level), .overflow(b_ovf),
        .underflow(b_unf), .clr_err(b_clr)
    );

    int total = 0;
    int bad   = 0;

    // Reference models: queue contents plus sticky flags and held read data.
    logic [31:0] qa[$];
    logic [31:0] ma_dout = '0;
    bit          ma_ovf = 1'b0, ma_unf = 1'b0;
    logic [15:0] qb[$];
    bit          mb_ovf = 1'b0, mb_unf = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_a();
        int n = qa.size();
        chk("a_level", a_level, n);
        chk("a_full", a_full, n == 16);
        chk("a_empty", a_empty, n == 0);
        chk("a_afull", a_af, n >= 14);
        chk("a_aempty", a_ae, n <= 2);
        chk("a_dout", a_dout, ma_dout);
        chk("a_ovf", a_ovf, ma_ovf);
        chk("a_unf", a_unf, ma_unf);
    endtask

    task automatic check_b();
        int n = qb.size();
        chk("b_level", b_level, n);
        chk("b_full", b_full, n == 5);
        chk("b_empty", b_empty, n == 0);
        chk("b_afull", b_af, n >= 3);
        chk("b_aempty", b_ae, n <= 2);
        chk("b_dout", b_dout, (n == 0) ? 16'h0 : qb[0]);
        chk("b_ovf", b_ovf, mb_ovf);
        chk("b_unf", b_unf, mb_unf);
    endtask

    task automatic step_a(input bit wr, input logic [31:0] din, input bit rd, input bit clr);
        bit f, e;
        a_wr = wr; a_din = din; a_rd = rd; a_clr = clr;
        @(posedge clk);
        f = (qa.size() == 16);
        e = (qa.size() == 0);
        if (rd && !e) ma_dout = qa.pop_front();
        if (wr && !f) qa.push_back(din);
        if (wr && f) ma_ovf = 1'b1; else if (clr) ma_ovf = 1'b0;
        if (rd && e) ma_unf = 1'b1; else if (clr) ma_unf = 1'b0;
        #1;
        a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0;
        check_a();
    endtask

    task automatic step_b(input bit wr, input logic [15:0] din, input bit rd, input bit clr);
        bit f, e;
        logic [15:0] dropped;
        b_wr = wr; b_din = din; b_rd = rd; b_clr = clr;
        @(posedge clk);
        f = (qb.size() == 5);
        e = (qb.size() == 0);
        if (rd && !e) dropped = qb.pop_front();
        if (wr && !f) qb.push_back(din);
        if (wr && f) mb_ovf = 1'b1; else if (clr) mb_ovf = 1'b0;
        if (rd && e) mb_unf = 1'b1; else if (clr) mb_unf = 1'b0;
        #1;
        b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0;
        check_b();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_a();
        check_b();
        rst = 1'b0;

        // Fill to 15, then to full, then overflow handling.
        for (int i = 0; i < 15; i++) step_a(1'b1, 32'h11 + i, 1'b0, 1'b0);
        chk("a_lvl15", a_level, 15);
        chk("a_af15", a_af, 1);
        chk("a_full15", a_full, 0);
        step_a(1'b1, 32'h20, 1'b0, 1'b0);
        chk("a_full16", a_full, 1);
        step_a(1'b1, 32'hDEAD, 1'b0, 1'b0);
        chk("a_ovf_set", a_ovf, 1);
        step_a(1'b0, 32'h0, 1'b0, 1'b1);
        chk("a_ovf_clr", a_ovf, 0);
        step_a(1'b1, 32'hDEAD, 1'b0, 1'b1);
        chk("a_ovf_prio", a_ovf, 1);
        for (int i = 0; i < 16; i++) step_a(1'b0, 32'h0, 1'b1, 1'b0);
        chk("a_last", a_dout, 32'h20);

        // Underflow, then simultaneous write/read on empty.
        step_a(1'b0, 32'h0, 1'b1, 1'b0);
        chk("a_unf_set", a_unf, 1);
        chk("a_unf_hold", a_dout, 32'h20);
        step_a(1'b1, 32'h55, 1'b1, 1'b0);
        chk("a_wr_on_empty", a_level, 1);

        // Sustained throughput at level 8.
        step_a(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step_a(1'b1, 32'h60 + i, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step_a(1'b1, 32'h100 + i, 1'b1, 1'b0);
        chk("a_thru_lvl", a_level, 8);

        for (int i = 0; i < 400; i++)
            step_a($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 45,
                   $urandom_range(0, 99) < 5);

        // FWFT instance: interleaved traffic wrapping the 5-deep pointers.
        for (int i = 0; i < 13; i++) step_b(1'b1, 16'hB0 + 16'(i), (i % 3) != 0, 1'b0);
        while (qb.size() > 0) step_b(1'b0, 16'h0, 1'b1, 1'b0);
        step_b(1'b0, 16'h0, 1'b1, 1'b0);
        chk("b_empty_zero", b_dout, 0);
        for (int i = 0; i < 300; i++)
            step_b($urandom_range(0, 99) < 50, 16'($urandom), $urandom_range(0, 99) < 50,
                   $urandom_range(0, 99) < 5);

        // Asynchronous reset with six words buffered.
        while (qa.size() > 0) step_a(1'b0, 32'h0, 1'b1, 1'b0);
        step_a(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step_a(1'b1, 32'h700 + i, 1'b0, 1'b0);
        chk("a_lvl6", a_level, 6);
        #2 rst = 1'b1;
        #1;
        qa.delete(); ma_dout = '0; ma_ovf = 1'b0; ma_unf = 1'b0;
        qb.delete(); mb_ovf = 1'b0; mb_unf = 1'b0;
        check_a();
        check_b();
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) step_a(1'b1, 32'h900 + i, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step_a(1'b0, 32'h0, 1'b1, 1'b0);
        chk("a_post_rst", a_dout, 32'h902);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/daq_sync_fifo.md
# daq_sync_fifo

Parametrised single-clock FIFO for the DAQ datapath, used between sample capture and packetiser/readout logic. It supersedes the basic FIFO with:
- any depth, including non-power-of-two;
- a selectable first-word-fall-through (FWFT) read mode;
- programmable almost-full/almost-empty thresholds;
- a fill-level output;
- sticky overflow/underflow error flags.

## Interface
- DATA_WIDTH, 32, word width in bits (≥1)
- DEPTH, 16, storage depth in words (≥2, any integer)
- FWFT, 0, 0 = registered read (standard), 1 = first-word-fall-through
- AFULL_THRESH, DEPTH-2, almost_full asserted when level ≥ this
- AEMPTY_THRESH, 2, almost_empty asserted when level ≤ this

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- rd_en  in  1  read request
- data_out  out  DATA_WIDTH  read data
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level ≥ AFULL_THRESH
- almost_empty  out  1  level ≤ AEMPTY_THRESH
- level  out  $clog2(DEPTH+1)  words currently stored
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- clr_err  in  1  synchronous clear of overflow/underflow

## Operation
- Write accepted iff wr_en && !full. Read accepted iff rd_en && !empty. full/empty are the registered values at the clock edge.
- Pointers wr_ptr/rd_ptr range 0..DEPTH-1. Each increments on an accepted op and wraps from DEPTH-1 to 0 explicitly; binary rollover is not relied on.
- level is an explicit register, width $clog2(DEPTH+1). Its next value depends on the accepted ops:
  - write only: +1
  - read only: −1
  - both or neither: unchanged
- Simultaneous wr_en && rd_en:
  - not full, not empty: both accepted, level unchanged. A read at the same address as a write returns the old (stored) word.
  - full: read accepted, write rejected, overflow set.
  - empty: write accepted, read rejected, underflow set.
- Standard mode (FWFT=0): on an accepted read, data_out ← mem[rd_ptr]. Otherwise data_out holds its last value.
- FWFT mode (FWFT=1): data_out = mem[rd_ptr] combinationally while !empty, and 0 while empty. An accepted read advances to the next word.
- overflow ← 1 on wr_en && full. underflow ← 1 on rd_en && empty.
- clr_err clears both flags; a set event in the same cycle takes priority over the clear.
- Storage array is not reset.

## Timing
- Reset values (asynchronous): wr_ptr=0, rd_ptr=0, level=0, data_out=0, empty=1, full=0, almost_empty=1, almost_full=(AFULL_THRESH==0), overflow=0, underflow=0.
- All status outputs are decoded from the level register. They reflect an accepted op from the clock edge that performs it (0-cycle flag latency after that edge).
- Standard mode read latency: rd_en accepted at edge N → data_out valid after edge N.
- FWFT latency: write to an empty FIFO at edge N → empty=0 and data_out = written word after edge N.
- Throughput: one write and one read per cycle sustained.
- Reset mid-operation: contents are discarded and the FIFO reports empty immediately, without waiting for a clock edge.

## Test plan
- Reset, then write 0x11..0x1F (15 words, DEPTH=16) → level=15, almost_full=1, full=0. Write 0x20 → full=1. Read all 16 → data order 0x11..0x20, empty=1, almost_empty=1 from level 2.
- Full FIFO, wr_en=1 with data 0xDEAD → overflow=1, level stays 16, 0xDEAD never read. Pulse clr_err → overflow=0. Assert wr_en and clr_err together while full → overflow stays 1.
- Empty FIFO, rd_en=1 → underflow=1, data_out unchanged. Then wr_en && rd_en with 0x55 → write accepted, level=1, underflow=1.
- Level 8, wr_en && rd_en for 20 cycles with incrementing data → level stays 8, output sequence in order, no flags set.
- DEPTH=5, FWFT=1: write and read 13 words interleaved to force pointer wrap at 4→0 → data_out equals each word in order, 0 while empty, data visible the cycle after the first write.
- Assert rst asynchronously mid-burst (level=6) → all outputs at reset values before the next edge. A subsequent read sequence returns only data written after reset.
